// File: rtl/full_adder_pkg.sv
// Shared bit-level helpers for the full_adder datapath slice.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    // Returns {carry_out, sum} for one bit position.
    function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Pure combinational 1-bit full adder cell; the building block of the ripple chain.
module fa_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic [1:0] res;

    assign res = fa_bit(a, b, ci);
    assign s   = res[0];
    assign co  = res[1];

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from fa_cell instances, with an optional output register
// stage. With REG_OUT=1 results appear one clock after capture; with REG_OUT=0 the
// adder is purely combinational and clk/rst are not used.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = FA_DEFAULT_WIDTH,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] s_q;
        logic             cout_q;
        logic             valid_q;

        // Capture the sum on qualified cycles; otherwise hold it and drop valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                s_q     <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    s_q    <= sum_comb;
                    cout_q <= carry[WIDTH];
                end
            end
        end

        assign S         = s_q;
        assign Cout      = cout_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        // Clock and reset are intentionally unused in the combinational variant.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign S         = sum_comb;
        assign Cout      = carry[WIDTH];
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks for full_adder in registered and combinational forms.
module tb_full_adder;

    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, iv1 = 1'b0;
    logic       s1, cout1, ov1;
    logic       sc, coutc, ovc;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0, iv8 = 1'b0;
    logic [7:0] s8;
    logic       cout8, ov8;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp9;
    logic [1:0] tt_exp;
    logic [7:0] ra, rb;
    logic       rc, riv;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut_r1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
        .S(s1), .Cout(cout1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dut_c1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
        .S(sc), .Cout(coutc), .out_valid(ovc)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut_r8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .in_valid(iv8),
        .S(s8), .Cout(cout8), .out_valid(ov8)
    );

    // Free-running clock that can be parked low for the combinational phase.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset state of both registered instances.
        rst = 1'b1;
        tick();
        chk("rst_init_r1", {29'd0, ov1, cout1, s1}, 32'h0);
        chk("rst_init_r8", {22'd0, ov8, cout8, s8}, 32'h0);
        rst = 1'b0;

        // Exhaustive truth table, one vector per clock, result one clock later.
        iv1 = 1'b1;
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin1} = 3'(v);
            case (v)
                0:       tt_exp = 2'b00;
                1, 2, 4: tt_exp = 2'b01;
                3, 5, 6: tt_exp = 2'b10;
                default: tt_exp = 2'b11;
            endcase
            tick();
            chk($sformatf("tt_%0d", v), {30'd0, cout1, s1}, {30'd0, tt_exp});
            chk($sformatf("tt_valid_%0d", v), {31'd0, ov1}, 32'd1);
        end

        // Reset with valid inputs pending: rst wins.
        {a1, b1, cin1} = 3'b111;
        iv1 = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_edge1", {29'd0, ov1, cout1, s1}, 32'h0);
        tick();
        chk("rst_edge2", {29'd0, ov1, cout1, s1}, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst", {29'd0, ov1, cout1, s1}, 32'h7);

        // Hold: capture 1+0+1, then drop in_valid and disturb inputs.
        {a1, b1, cin1} = 3'b101;
        tick();
        chk("hold_cap", {29'd0, ov1, cout1, s1}, 32'h6);
        iv1 = 1'b0;
        {a1, b1, cin1} = 3'b010;
        #2;
        chk("mid_cycle", {29'd0, ov1, cout1, s1}, 32'h6);
        tick();
        chk("hold_1", {29'd0, ov1, cout1, s1}, 32'h2);
        {a1, b1, cin1} = 3'b111;
        tick();
        chk("hold_2", {29'd0, ov1, cout1, s1}, 32'h2);

        // Wrap cases on the 8-bit instance.
        iv8 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        tick();
        chk("wrap_ff_01", {22'd0, ov8, cout8, s8}, 32'h300);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        chk("wrap_ff_ff_1", {22'd0, ov8, cout8, s8}, 32'h3FF);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick();
        chk("zero8", {22'd0, ov8, cout8, s8}, 32'h200);
        exp9 = 9'h000;

        // Random stream against a 9-bit model; hold behaviour when in_valid is low.
        for (int k = 0; k < 1000; k++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom_range(0, 1));
            riv = 1'($urandom_range(0, 1));
            a8 = ra; b8 = rb; cin8 = rc; iv8 = riv;
            tick();
            if (riv) exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            chk("rnd_valid", {31'd0, ov8}, {31'd0, riv});
            chk("rnd_sum", {23'd0, cout8, s8}, {23'd0, exp9});
        end
        iv8 = 1'b0;

        // Combinational instance with the clock parked.
        @(negedge clk);
        clk_en = 1'b0;
        iv1 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin1} = 3'(v);
            iv1 = ~iv1;
            case (v)
                0:       tt_exp = 2'b00;
                1, 2, 4: tt_exp = 2'b01;
                3, 5, 6: tt_exp = 2'b10;
                default: tt_exp = 2'b11;
            endcase
            #5;
            chk($sformatf("comb_%0d", v), {30'd0, coutc, sc}, {30'd0, tt_exp});
            chk($sformatf("comb_valid_%0d", v), {31'd0, ovc}, {31'd0, iv1});
            #5;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
